mpu_host_link: RTL and testbench
================================

MPU_HOST_LINK -- requirements
Module: mpu_host_link

Interface
REQ-001 Parameters (name, default, meaning); the block SHALL honour each:
- CMD_DEPTH, 4: command FIFO entries, power of two.
- STROBE_CYCLES, 2: cycles receive is held high.
- GAP_CYCLES, 8: idle cycles after each instruction before the next setup.
- RSP_DELAY, 4: cycles from send-high detection to data capture.
- TIMEOUT, 255: maximum cycles to wait for send.
REQ-002 Ports (name, direction, width, meaning); the block SHALL provide exactly these:
- clock, in, 1: single clock; all state on rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- cmd_data, in, 32: instruction from the host.
- cmd_valid, in, 1: cmd_data valid.
- cmd_ready, out, 1: FIFO not full.
- instruction_out, out, 32: instruction bus to the MPU instruction_in.
- receive, out, 1: registered strobe to the MPU receive.
- mpu_data_in, in, 16: MPU data_out.
- mpu_send, in, 1: MPU send.
- rsp_data, out, 16: captured LOAD result.
- rsp_valid, out, 1: rsp_data valid.
- rsp_ready, in, 1: host accepts the response.
- busy, out, 1: FSM not IDLE or FIFO not empty.
- timeout_err, out, 1: sticky, set when a LOAD receives no send.

Function
REQ-003 Command push SHALL occur when cmd_valid and cmd_ready are both high; cmd_ready SHALL equal !full.
REQ-004 The FSM SHALL have the states IDLE, SETUP, STROBE, HOLD, WAIT_SEND, CAPTURE, GAP, with these transitions:
- IDLE to SETUP: FIFO not empty and (!rsp_valid or the head opcode is not LOAD).
- SETUP, 1 cycle: pop the head, drive it on instruction_out, receive=0.
- STROBE: receive=1 for STROBE_CYCLES.
- HOLD, 1 cycle: receive=0.
- HOLD to WAIT_SEND if opcode==LOAD, otherwise to GAP.
REQ-005 instruction_out SHALL stay constant from SETUP through the end of GAP, giving at least 1 cycle of setup and hold around the receive rising edge.
REQ-006 receive SHALL be driven directly from a flop (glitch-free) because the MPU clocks its instruction on the receive edge.
REQ-007 The opcode SHALL be cmd bits [3:0]; LOAD is opcode 6.
REQ-008 WAIT_SEND SHALL count cycles:
- mpu_send high: go to CAPTURE.
- Count reaches TIMEOUT: set timeout_err, load rsp_data=16'hDEAD, set rsp_valid, go to GAP.
REQ-009 CAPTURE SHALL wait RSP_DELAY cycles, then latch mpu_data_in into rsp_data, set rsp_valid, and go to GAP.
REQ-010 GAP SHALL count GAP_CYCLES, then go to IDLE.
REQ-011 rsp_valid SHALL clear on a cycle where rsp_valid and rsp_ready are both high.
REQ-012 A new capture SHALL never occur while rsp_valid=1; REQ-004 blocks any LOAD issue until the pending response is drained.
REQ-013 A push and a pop in the same cycle on a full FIFO SHALL be legal and leave the count unchanged; a push while full SHALL be ignored.
REQ-014 Pointers SHALL wrap modulo CMD_DEPTH.
REQ-015 timeout_err SHALL clear only on reset.
REQ-016 An empty FIFO in IDLE SHALL hold all outputs stable; receive SHALL stay 0.

Reset
REQ-017 On reset_n low, all state SHALL clear immediately:
- FSM to IDLE; FIFO pointers and count to 0.
- receive=0, instruction_out=0, rsp_data=0.
- rsp_valid=0, timeout_err=0, busy=0.
- cmd_ready=1 once reset is released.
REQ-018 Reset during STROBE SHALL drop receive within the same cycle, asynchronously; queued commands are discarded.

Structure
REQ-019 Package mpu_pkg SHALL hold the opcode constants (LOAD=6, others 0-5), the FSM state typedef, and the error word 16'hDEAD.
REQ-020 The command FIFO SHALL be sub-module mpu_cmd_fifo: synchronous, parameterised depth and width, with full, empty and count outputs.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single non-LOAD push of 32'h0000_0012 -> after 1 cycle SETUP, receive high for exactly 2 cycles, instruction_out=32'h12 stable throughout, rsp_valid never set, busy low after GAP.
- LOAD 32'h0000_0006 with the model asserting send 3 cycles later and data 16'hBEEF -> rsp_data=16'hBEEF, rsp_valid high exactly 4 cycles after send is detected.
- LOAD with send held low -> after 255 cycles timeout_err=1, rsp_data=16'hDEAD, next command still issued.
- Push 5 commands back-to-back -> cmd_ready low after the 4th; the 5th is accepted once the first pops; issue order is preserved.
- Two LOADs with rsp_ready held low -> the second is not strobed until the first response is taken.
- reset_n low mid-STROBE -> receive=0 the same cycle, FIFO empty, FSM IDLE.

Source files
------------

// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - opcodes, FSM states and constants shared by the MPU host link
package mpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd6;

    localparam logic [15:0] ERR_WORD = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_WAIT_SEND,
        ST_CAPTURE,
        ST_GAP
    } state_e;

    function automatic logic is_load(input logic [3:0] opcode);
        return opcode == OP_LOAD;
    endfunction

endpackage

// File: rtl/mpu_cmd_fifo.sv
// rtl/mpu_cmd_fifo.sv - synchronous command FIFO, power-of-two depth (>= 2)
module mpu_cmd_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a push on full is accepted alongside it
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mpu_host_link.sv
// rtl/mpu_host_link.sv - queues host instructions and strobes them into the MPU, capturing LOAD results
module mpu_host_link
    import mpu_pkg::*;
#(
    parameter int CMD_DEPTH     = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 8,
    parameter int RSP_DELAY     = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [31:0] instruction_out,
    output logic        receive,
    input  logic [15:0] mpu_data_in,
    input  logic        mpu_send,
    output logic [15:0] rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        busy,
    output logic        timeout_err
);
    localparam int AW    = $clog2(CMD_DEPTH);
    localparam int MAX_A = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int MAX_B = (RSP_DELAY > STROBE_CYCLES) ? RSP_DELAY : STROBE_CYCLES;
    localparam int CNT_W = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);

    localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RSP_LAST     = CNT_W'(RSP_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        instr_q, instr_d;
    logic               receive_q, receive_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               timeout_q, timeout_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]        fifo_head;
    logic [AW:0]        fifo_count;
    logic               capture_fire, timeout_fire;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    mpu_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (32)
    ) u_cmd_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .wdata_i (cmd_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            instr_q     <= '0;
            receive_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            receive_q   <= receive_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // A LOAD waits in the FIFO while a response is pending; other opcodes may still go out
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && (!rsp_valid_q || !is_load(fifo_head[3:0]))) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_STROBE;
            ST_STROBE: begin
                if (cnt_q == STROBE_LAST) state_d = ST_HOLD;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            ST_HOLD: state_d = is_load(instr_q[3:0]) ? ST_WAIT_SEND : ST_GAP;
            ST_WAIT_SEND: begin
                if (mpu_send)                   state_d = ST_CAPTURE;
                else if (cnt_q == TIMEOUT_LAST) state_d = ST_GAP;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            ST_CAPTURE: begin
                if (cnt_q == RSP_LAST) state_d = ST_GAP;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Instruction is latched on entry to SETUP so it is stable a full cycle before receive rises
    always_comb begin
        fifo_pop     = (state_q == ST_IDLE) && (state_d == ST_SETUP);
        capture_fire = (state_q == ST_CAPTURE) && (state_d == ST_GAP);
        timeout_fire = (state_q == ST_WAIT_SEND) && (state_d == ST_GAP);
        instr_d      = fifo_pop ? fifo_head : instr_q;
        receive_d    = (state_d == ST_STROBE);
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q && !rsp_ready;
        if (capture_fire) begin
            rsp_data_d  = mpu_data_in;
            rsp_valid_d = 1'b1;
        end else if (timeout_fire) begin
            rsp_data_d  = ERR_WORD;
            rsp_valid_d = 1'b1;
        end
        timeout_d = timeout_q || timeout_fire;
    end

    assign instruction_out = instr_q;
    assign receive         = receive_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_valid       = rsp_valid_q;
    assign timeout_err     = timeout_q;
    assign busy            = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_mpu_host_link.sv
// tb/tb_mpu_host_link.sv - directed and randomized bench for mpu_host_link
module tb_mpu_host_link;
    localparam int DEPTH  = 4;
    localparam int STROBE = 2;
    localparam int GAP    = 8;
    localparam int RSPD   = 4;
    localparam int TO     = 255;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] instruction_out;
    logic        receive;
    logic [15:0] mpu_data_in;
    logic        mpu_send;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        busy;
    logic        timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] burst [5] = '{32'h0000_0101, 32'h0000_0202, 32'h0000_0303,
                               32'h0000_0404, 32'h0000_0505};
    logic [31:0] q_cmd [$];
    logic [15:0] q_rsp [$];

    mpu_host_link #(
        .CMD_DEPTH     (DEPTH),
        .STROBE_CYCLES (STROBE),
        .GAP_CYCLES    (GAP),
        .RSP_DELAY     (RSPD),
        .TIMEOUT       (TO)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cmd_data        (cmd_data),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .instruction_out (instruction_out),
        .receive         (receive),
        .mpu_data_in     (mpu_data_in),
        .mpu_send        (mpu_send),
        .rsp_data        (rsp_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return receive;
            1:       return rsp_valid;
            default: return busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic level, input int bound, input string tag);
        int   n = 0;
        logic cur;
        cur = sel(which);
        while (cur !== level && n < bound) begin
            step();
            n++;
            cur = sel(which);
        end
        chk(tag, 32'(cur), 32'(level));
    endtask

    task automatic push(input logic [31:0] d, input string tag);
        int n = 0;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int          hi;
        int          rises;
        logic        prev;
        logic        pv, tv, prev_rcv;
        logic [15:0] pre_rsp;
        logic [31:0] d, exp_i, exp_r;

        reset_n     = 1'b0;
        cmd_data    = '0;
        cmd_valid   = 1'b0;
        mpu_data_in = '0;
        mpu_send    = 1'b0;
        rsp_ready   = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_receive", 32'(receive), 32'd0);
        chk("rst_instr", instruction_out, 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single non-LOAD instruction
        push(32'h0000_0012, "t1_push");
        step();
        chk("t1_setup_receive", 32'(receive), 32'd0);
        chk("t1_setup_instr", instruction_out, 32'h12);
        step();
        hi = 0;
        while (receive && hi < 20) begin
            hi++;
            chk("t1_strobe_instr", instruction_out, 32'h12);
            step();
        end
        chk("t1_strobe_len", 32'(hi), 32'(STROBE));
        repeat (GAP) step();
        chk("t1_gap_busy", 32'(busy), 32'd1);
        chk("t1_gap_instr", instruction_out, 32'h12);
        chk("t1_no_rsp", 32'(rsp_valid), 32'd0);
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_instr", instruction_out, 32'h12);

        // LOAD with send three cycles into the wait
        push(32'h0000_0006, "t2_push");
        wait_for(0, 1'b1, 10, "t2_rise");
        chk("t2_instr", instruction_out, 32'h6);
        wait_for(0, 1'b0, 10, "t2_fall");
        repeat (3) step();
        mpu_send    = 1'b1;
        mpu_data_in = 16'hBEEF;
        repeat (RSPD) step();
        chk("t2_rsp_early", 32'(rsp_valid), 32'd0);
        step();
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_data", 32'(rsp_data), 32'hBEEF);
        mpu_send    = 1'b0;
        mpu_data_in = '0;
        rsp_ready   = 1'b1;
        step();
        chk("t2_rsp_taken", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        wait_for(2, 1'b0, 40, "t2_idle");

        // LOAD with no send, followed by another instruction
        push(32'h0000_1236, "t3_push_load");
        push(32'h0000_0033, "t3_push_next");
        wait_for(0, 1'b1, 10, "t3_rise");
        chk("t3_instr", instruction_out, 32'h1236);
        wait_for(0, 1'b0, 10, "t3_fall");
        repeat (TO) step();
        chk("t3_timeout_early", 32'(timeout_err), 32'd0);
        step();
        chk("t3_timeout", 32'(timeout_err), 32'd1);
        chk("t3_dead", 32'(rsp_data), 32'hDEAD);
        chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        wait_for(0, 1'b1, 30, "t3_next_rise");
        chk("t3_next_instr", instruction_out, 32'h33);
        rsp_ready = 1'b1;
        step();
        chk("t3_rsp_taken", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        wait_for(2, 1'b0, 40, "t3_idle");
        chk("t3_sticky", 32'(timeout_err), 32'd1);

        // Five back-to-back pushes while the link is busy
        push(32'h0000_0045, "t4_push_pre");
        wait_for(0, 1'b1, 10, "t4_pre_rise");
        for (int i = 0; i < 4; i++) begin
            cmd_data  = burst[i];
            cmd_valid = 1'b1;
            chk("t4_ready", 32'(cmd_ready), 32'd1);
            step();
        end
        chk("t4_full", 32'(cmd_ready), 32'd0);
        cmd_data = burst[4];
        hi = 0;
        while (!cmd_ready && hi < 40) begin
            step();
            hi++;
        end
        chk("t4_fifth_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_for(0, 1'b1, 40, "t4_rise");
            chk("t4_order", instruction_out, burst[i]);
            wait_for(0, 1'b0, 10, "t4_fall");
        end
        wait_for(2, 1'b0, 40, "t4_idle");

        // Two LOADs with the first response left pending
        mpu_send    = 1'b1;
        mpu_data_in = 16'h1111;
        push(32'h0000_0A06, "t5_push_a");
        push(32'h0000_0B06, "t5_push_b");
        wait_for(0, 1'b1, 10, "t5_rise_a");
        chk("t5_instr_a", instruction_out, 32'h0A06);
        wait_for(1, 1'b1, 20, "t5_rsp_a");
        chk("t5_data_a", 32'(rsp_data), 32'h1111);
        mpu_data_in = 16'h2222;
        rises = 0;
        prev  = receive;
        repeat (40) begin
            step();
            if (receive && !prev) rises++;
            prev = receive;
        end
        chk("t5_blocked", 32'(rises), 32'd0);
        rsp_ready = 1'b1;
        step();
        chk("t5_taken_a", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        wait_for(0, 1'b1, 20, "t5_rise_b");
        chk("t5_instr_b", instruction_out, 32'h0B06);
        wait_for(1, 1'b1, 20, "t5_rsp_b");
        chk("t5_data_b", 32'(rsp_data), 32'h2222);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        mpu_send  = 1'b0;
        wait_for(2, 1'b0, 40, "t5_idle");

        // Reset in the middle of a strobe
        push(32'h0000_0011, "t6_push0");
        push(32'h0000_0022, "t6_push1");
        push(32'h0000_0033, "t6_push2");
        wait_for(0, 1'b1, 10, "t6_rise");
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_receive", 32'(receive), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_instr", instruction_out, 32'd0);
        chk("t6_timeout_clr", 32'(timeout_err), 32'd0);
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) step();
        reset_n = 1'b1;
        rises = 0;
        repeat (20) begin
            step();
            if (receive) rises++;
        end
        chk("t6_discarded", 32'(rises), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        // Randomized traffic against a queue model, then drain
        mpu_send = 1'b1;
        for (int it = 0; it < 2200; it++) begin
            d = $urandom;
            if ($urandom_range(0, 2) == 0) d[3:0] = 4'd6;
            else                           d[3:0] = 4'($urandom_range(0, 5));
            cmd_data  = d;
            cmd_valid = ($urandom_range(0, 2) == 0);
            rsp_ready = 1'($urandom_range(0, 1));
            if (it >= 2000) begin
                cmd_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            pv       = cmd_valid && cmd_ready;
            tv       = rsp_valid && rsp_ready;
            pre_rsp  = rsp_data;
            prev_rcv = receive;
            step();
            if (pv) q_cmd.push_back(d);
            if (tv) begin
                if (q_rsp.size() != 0) exp_r = 32'(q_rsp.pop_front());
                else                   exp_r = 32'hFFFF_FFFF;
                chk("rnd_rsp", 32'(pre_rsp), exp_r);
            end
            if (receive && !prev_rcv) begin
                if (q_cmd.size() != 0) exp_i = q_cmd.pop_front();
                else                   exp_i = 'x;
                chk("rnd_instr", instruction_out, exp_i);
                if (exp_i[3:0] == 4'd6) begin
                    chk("rnd_load_pending", 32'(rsp_valid), 32'd0);
                    mpu_data_in = 16'($urandom);
                    q_rsp.push_back(mpu_data_in);
                end
            end
        end
        chk("rnd_drain_busy", 32'(busy), 32'd0);
        chk("rnd_drain_rsp", 32'(rsp_valid), 32'd0);
        chk("rnd_cmd_left", 32'(q_cmd.size()), 32'd0);
        chk("rnd_rsp_left", 32'(q_rsp.size()), 32'd0);
        chk("rnd_no_timeout", 32'(timeout_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
